adc128s052_responder: RTL and testbench
=======================================

Name: adc128s052_responder

Overview:
- Synthesizable SPI-slave model of the ADC128S052 8-channel 12-bit ADC.
- Responds to the capture block's SCLK/CS/DIN and drives DOUT, oversampling all pins in the system clock domain.
- Conversion results come from eight host-writable channel registers.
- Used in loopback benches and on boards with no ADC fitted.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each of sclk, cs, din before edge detection (min 2).
- RESET_CH_VAL, 12'h000, reset value of all eight channel registers.

Ports:
- clk  input  1  system clock; frequency must be at least 8x sclk.
- rst  input  1  synchronous, active-high reset.
- sclk  input  1  serial clock from master; asynchronous to clk.
- cs  input  1  chip select, active low; asynchronous.
- din  input  1  control bits from master; asynchronous.
- dout  output  1  serial data to master.
- wr_en  input  1  host write strobe for a channel register.
- wr_addr  input  3  channel register index 0-7.
- wr_data  input  12  value for the addressed channel.
- cur_addr  output  3  channel that will be converted in the next frame.
- ctrl_byte  output  8  last complete 8-bit control word sampled on DIN.
- active  output  1  high while synchronized cs is low.
- frame_done  output  1  one-clk pulse when the 16th rising SCLK edge of a frame is seen.
- frame_abort  output  1  one-clk pulse when cs rises with 1-15 rising edges counted.

Behaviour:
- Reset values:
  - dout=0, cur_addr=0, ctrl_byte=0, active=0, frame_done=0, frame_abort=0.
  - Rising-edge count=0, falling-edge count=0, all channel registers=RESET_CH_VAL.
  - Synchronizers cleared to sclk=1, cs=1, din=0.
- Reset mid-frame: immediate return to idle. The in-flight frame is discarded with no done/abort pulse. cur_addr returns to 0.
- Synchronization and edges:
  - sclk_s, cs_s, din_s are the synchronizer outputs.
  - Edges are detected by comparing each with its previous registered value.
  - Pin-to-response latency: SYNC_STAGES+1 clk.
  - SCLK edges are counted only while cs_s is low. A sclk_s edge in the same clk as the cs_s falling edge is ignored.
- Frame word: {4'b0000, ch[cur_addr]}, bits 15..0.
- On cs_s falling edge:
  - Load the frame word.
  - dout <= bit15 (0).
  - Rise count <= 0, fall count <= 0.
- Each sclk_s rising edge, rise count r increments 1..16:
  - Sample din_s into the control shift register on edges 1-8.
  - ctrl_byte updates at r=8.
  - din_s at r=3,4,5 is captured as next_addr[2], [1], [0].
- On r=16:
  - frame_done pulses.
  - cur_addr <= next_addr.
  - Load a new frame word using the new cur_addr.
  - Rise count <= 0 (continuous mode: the master may keep clocking without toggling cs).
- Each sclk_s falling edge, fall count f increments:
  - For f=1..15: dout <= word bit (15-f).
  - The falling edge after r=16 drives bit15 of the new word and sets f to 0.
- On cs_s rising edge:
  - If 1 <= r <= 15: frame_abort pulses.
  - If r>=5 at that point, cur_addr <= next_addr; otherwise cur_addr is unchanged.
  - dout <= 0 while idle. Counts clear.
  - A cs_s rise coincident with r=16 gives frame_done only.
- Channel writes:
  - A write takes effect on the next clk.
  - The word already loaded for the current frame is unaffected.
  - A write in the same clk as a word load is not seen by that load (old value used).
- Extra falling edges before the first rising edge are ignored (f stays 0).
- Data timing: the master samples dout on SCLK rising edges. DB11 is valid from the 4th falling edge through the 5th rising edge.

Test Plan:
- Reset: rst high 3 clk -> dout=0, cur_addr=0, active=0, no pulses; a frame returns 16'h0000 with RESET_CH_VAL=0.
- Two-frame address: write ch0=12'hABC, ch5=12'h123; frame 1 with DIN byte 8'b00101000 -> master reads 16'h0ABC, frame_done=1, cur_addr=5; frame 2 -> reads 16'h0123.
- Continuous mode: cs held low for 32 SCLK, DIN addresses 3 then 7, ch3=12'h00F, ch7=12'hFFF, prior cur_addr=0, ch0=12'h555 -> words 16'h0555 then 16'h000F; two frame_done pulses; cur_addr=7.
- Abort: cs rises after 3 rising edges -> frame_abort pulse, cur_addr unchanged. Abort after 6 edges with addr 2 -> frame_abort pulse, cur_addr=2.
- Write during frame: ch0=12'h111, change to 12'h222 at rising edge 8 -> frame reads 16'h0111; next frame to ch0 reads 16'h0222.
- Reset mid-frame: assert rst at rising edge 10 -> dout=0, no frame_done, cur_addr=0; the next full frame is correct.

Source files
------------

// File: rtl/adc128s052_responder.sv
// ============================================================================
// Module   : adc128s052_responder
// Brief    : SPI-slave model of the ADC128S052 8-channel 12-bit ADC, with
//            host-writable channel registers, oversampled in the clk domain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adc128s052_responder #(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [11:0] RESET_CH_VAL = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk_i,
  input  logic        cs_i,
  input  logic        din_i,
  output logic        dout_o,
  input  logic        wr_en_i,
  input  logic [2:0]  wr_addr_i,
  input  logic [11:0] wr_data_i,
  output logic [2:0]  cur_addr_o,
  output logic [7:0]  ctrl_byte_o,
  output logic        active_o,
  output logic        frame_done_o,
  output logic        frame_abort_o
);

  localparam logic [4:0] C_LAST_RISE = 5'd16;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, din_sync_q;
  logic        sclk_prev_q, cs_prev_q;
  logic [11:0] ch_q [8];

  logic [4:0]  rcnt_q, rcnt_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [15:0] word_q, word_d;
  logic        dout_q, dout_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [2:0]  next_addr_q, next_addr_d;
  logic [2:0]  cur_addr_q, cur_addr_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;

  logic        w_sclk_s, w_cs_s, w_din_s;
  logic        w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise, w_in_frame;
  logic [4:0]  w_r_inc;

  assign w_sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign w_cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign w_din_s     = din_sync_q[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~sclk_prev_q;
  assign w_sclk_fall = ~w_sclk_s & sclk_prev_q;
  assign w_cs_fall   = ~w_cs_s & cs_prev_q;
  assign w_cs_rise   = w_cs_s & ~cs_prev_q;
  // Edges count in the clk where cs rises (a late 16th edge still completes the
  // frame) but not in the clk where cs falls.
  assign w_in_frame  = ~cs_prev_q;
  assign w_r_inc     = rcnt_q + 5'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      din_sync_q  <= '0;
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], din_i};
      sclk_prev_q <= w_sclk_s;
      cs_prev_q   <= w_cs_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) ch_q[i] <= RESET_CH_VAL;
    end else if (wr_en_i) begin
      ch_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    rcnt_d      = rcnt_q;
    fcnt_d      = fcnt_q;
    word_d      = word_q;
    dout_d      = dout_q;
    shift_d     = shift_q;
    ctrl_d      = ctrl_q;
    next_addr_d = next_addr_q;
    cur_addr_d  = cur_addr_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;

    if (w_cs_fall) begin
      word_d = {4'b0000, ch_q[cur_addr_q]};
      dout_d = 1'b0;
      rcnt_d = 5'd0;
      fcnt_d = 4'd0;
    end else if (w_in_frame) begin
      if (w_sclk_rise) begin
        rcnt_d = w_r_inc;
        if (w_r_inc <= 5'd8) shift_d = {shift_q[6:0], w_din_s};
        if (w_r_inc == 5'd8) ctrl_d = {shift_q[6:0], w_din_s};
        if (w_r_inc == 5'd3) next_addr_d[2] = w_din_s;
        if (w_r_inc == 5'd4) next_addr_d[1] = w_din_s;
        if (w_r_inc == 5'd5) next_addr_d[0] = w_din_s;
        if (w_r_inc == C_LAST_RISE) begin
          done_d     = 1'b1;
          cur_addr_d = next_addr_q;
          word_d     = {4'b0000, ch_q[next_addr_q]};
          rcnt_d     = 5'd0;
        end
      end else if (w_sclk_fall) begin
        // With no rising edge yet in this word, keep presenting its MSB.
        if (rcnt_q == 5'd0) begin
          dout_d = word_q[15];
          fcnt_d = 4'd0;
        end else if (fcnt_q < 4'd15) begin
          dout_d = word_q[4'd14 - fcnt_q];
          fcnt_d = fcnt_q + 4'd1;
        end
      end

      if (w_cs_rise) begin
        if (!done_d && rcnt_d != 5'd0) abort_d = 1'b1;
        if (!done_d && rcnt_d >= 5'd5) cur_addr_d = next_addr_d;
        dout_d = 1'b0;
        rcnt_d = 5'd0;
        fcnt_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q      <= 5'd0;
      fcnt_q      <= 4'd0;
      word_q      <= 16'h0000;
      dout_q      <= 1'b0;
      shift_q     <= 8'h00;
      ctrl_q      <= 8'h00;
      next_addr_q <= 3'd0;
      cur_addr_q  <= 3'd0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      rcnt_q      <= rcnt_d;
      fcnt_q      <= fcnt_d;
      word_q      <= word_d;
      dout_q      <= dout_d;
      shift_q     <= shift_d;
      ctrl_q      <= ctrl_d;
      next_addr_q <= next_addr_d;
      cur_addr_q  <= cur_addr_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
    end
  end

  assign dout_o        = dout_q;
  assign cur_addr_o    = cur_addr_q;
  assign ctrl_byte_o   = ctrl_q;
  assign active_o      = ~w_cs_s;
  assign frame_done_o  = done_q;
  assign frame_abort_o = abort_q;

endmodule

`default_nettype wire

// File: tb/tb_adc128s052_responder.sv
// ============================================================================
// Module   : tb_adc128s052_responder
// Brief    : Directed plus randomized SPI-master bench with a channel/address model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_adc128s052_responder;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b1, cs = 1'b1, din = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [11:0] wr_data = 12'h000;
  logic        dout, active, frame_done, frame_abort;
  logic [2:0]  cur_addr;
  logic [7:0]  ctrl_byte;

  int vectors = 0, miscompares = 0;
  int done_cnt = 0, abort_cnt = 0;

  logic [11:0] m_mem [8];
  logic [2:0]  m_cur;

  adc128s052_responder #(.SYNC_STAGES(2), .RESET_CH_VAL(12'h000)) dut (
    .clk(clk), .rst(rst), .sclk_i(sclk), .cs_i(cs), .din_i(din), .dout_o(dout),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .cur_addr_o(cur_addr), .ctrl_byte_o(ctrl_byte), .active_o(active),
    .frame_done_o(frame_done), .frame_abort_o(frame_abort)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done)  done_cnt  <= done_cnt + 1;
    if (frame_abort) abort_cnt <= abort_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [11:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    wait_clks(1);
    wr_en = 1'b0;
    m_mem[a] = d;
  endtask

  // Master: SCLK idles high, DIN changes on falling edges, DOUT sampled at rising edges.
  task automatic spi_xfer(input logic [31:0] tx, input int n, input bit end_cs,
                          input int wr_at, input logic [2:0] wa, input logic [11:0] wd,
                          output logic [31:0] rx);
    rx = '0;
    cs = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      din  = tx[31-i];
      wait_clks(HALF);
      rx   = {rx[30:0], dout};
      sclk = 1'b1;
      if (i + 1 == wr_at) begin
        host_write(wa, wd);
        wait_clks(HALF - 1);
      end else begin
        wait_clks(HALF);
      end
    end
    if (end_cs) begin
      cs = 1'b1;
      wait_clks(6);
    end
  endtask

  // Full 16-edge frame checked against the model.
  task automatic full_frame(input string tag, input logic [7:0] ctrl);
    logic [31:0] rx;
    logic [15:0] exp;
    int d0, a0;
    exp = {4'h0, m_mem[m_cur]};
    d0 = done_cnt; a0 = abort_cnt;
    spi_xfer({ctrl, 8'($urandom), 16'h0}, 16, 1'b1, 0, 3'd0, 12'h0, rx);
    m_cur = ctrl[5:3];
    check({tag, "_word"}, {16'h0, rx[15:0]}, {16'h0, exp});
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_noabort"}, abort_cnt - a0, 0);
    check({tag, "_addr"}, {29'h0, cur_addr}, {29'h0, m_cur});
    check({tag, "_ctrl"}, {24'h0, ctrl_byte}, {24'h0, ctrl});
  endtask

  task automatic abort_frame(input string tag, input logic [7:0] ctrl, input int n);
    logic [31:0] rx;
    int d0, a0;
    d0 = done_cnt; a0 = abort_cnt;
    spi_xfer({ctrl, 24'h0}, n, 1'b1, 0, 3'd0, 12'h0, rx);
    if (n >= 5) m_cur = ctrl[5:3];
    check({tag, "_abort"}, abort_cnt - a0, 1);
    check({tag, "_nodone"}, done_cnt - d0, 0);
    check({tag, "_addr"}, {29'h0, cur_addr}, {29'h0, m_cur});
    check({tag, "_dout"}, {31'h0, dout}, 32'h0);
  endtask

  initial begin
    logic [31:0] rx;
    logic [15:0] e1, e2;
    logic [7:0]  c;
    int d0;
    for (int i = 0; i < 8; i++) m_mem[i] = 12'h000;
    m_cur = 3'd0;

    // Reset
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2);
    check("rst_dout", {31'h0, dout}, 32'h0);
    check("rst_addr", {29'h0, cur_addr}, 32'h0);
    check("rst_active", {31'h0, active}, 32'h0);
    check("rst_ctrl", {24'h0, ctrl_byte}, 32'h0);
    check("rst_pulses", done_cnt + abort_cnt, 0);
    cs = 1'b0;
    wait_clks(5);
    check("active_low_cs", {31'h0, active}, 32'h1);
    cs = 1'b1;
    wait_clks(5);
    full_frame("rst_frame", 8'h00);

    // Two-frame address sequencing
    host_write(3'd0, 12'hABC);
    host_write(3'd5, 12'h123);
    full_frame("addr_f1", 8'b0010_1000);
    full_frame("addr_f2", 8'b0000_0000);

    // Continuous mode: 32 SCLK with cs held low
    host_write(3'd0, 12'h555);
    host_write(3'd3, 12'h00F);
    host_write(3'd7, 12'hFFF);
    e1 = {4'h0, m_mem[m_cur]};
    e2 = {4'h0, m_mem[3]};
    d0 = done_cnt;
    spi_xfer({8'b0001_1000, 8'h00, 8'b0011_1000, 8'h00}, 32, 1'b1, 0, 3'd0, 12'h0, rx);
    m_cur = 3'd7;
    check("cont_words", rx, {e1, e2});
    check("cont_done", done_cnt - d0, 2);
    check("cont_addr", {29'h0, cur_addr}, {29'h0, m_cur});

    // Aborts: too short to latch an address, then long enough
    abort_frame("abort3", 8'b0001_0000, 3);
    abort_frame("abort6", 8'b0001_0000, 6);

    // Channel write during a frame
    full_frame("to_ch0", 8'h00);
    host_write(3'd0, 12'h111);
    e1 = {4'h0, m_mem[0]};
    spi_xfer({8'h00, 24'h0}, 16, 1'b1, 8, 3'd0, 12'h222, rx);
    check("wr_mid_word", {16'h0, rx[15:0]}, {16'h0, e1});
    full_frame("wr_next", 8'h00);

    // Randomized frames against the model
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 3; j++) host_write(3'($urandom_range(0, 7)), 12'($urandom));
      c = 8'($urandom);
      full_frame($sformatf("rnd%0d", k), c);
    end

    // Reset in the middle of a frame
    d0 = done_cnt;
    spi_xfer({8'b0011_0000, 24'h0}, 10, 1'b0, 0, 3'd0, 12'h0, rx);
    rst = 1'b1;
    wait_clks(2);
    cs = 1'b1; sclk = 1'b1;
    wait_clks(4);
    for (int i = 0; i < 8; i++) m_mem[i] = 12'h000;
    m_cur = 3'd0;
    check("mrst_dout", {31'h0, dout}, 32'h0);
    check("mrst_addr", {29'h0, cur_addr}, 32'h0);
    check("mrst_nodone", done_cnt - d0, 0);
    rst = 1'b0;
    wait_clks(3);
    full_frame("post_rst0", 8'b0000_0000);
    host_write(3'd0, 12'hA5A);
    full_frame("post_rst1", 8'b0011_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
